// File: rtl/shift_add_datapath.sv
// Register datapath of the N-bit shift-and-add multiplier: operand/accumulator
// registers driven by the sequencer, plus a captured product with valid/ack handshake.
module shift_add_datapath #(
   parameter int unsigned N = 8
) (
   input  logic           clock,
   input  logic           n_reset,
   input  logic [N-1:0]   multiplicand_in,
   input  logic [N-1:0]   multiplier_in,
   input  logic           resetout,
   input  logic           add,
   input  logic           ready,
   output logic           Q0,
   output logic [2*N-1:0] product,
   output logic           product_valid,
   input  logic           product_ack,
   output logic           overrun
);

   logic [N-1:0]   m_q, m_d;
   logic [N-1:0]   q_q, q_d;
   logic [N-1:0]   a_q, a_d;
   logic           c_q, c_d;
   logic [2*N-1:0] product_q, product_d;
   logic           valid_q, valid_d;
   logic           overrun_q, overrun_d;
   logic           ready_prev_q;
   logic           complete;

   // Rising edge of ready marks the end of a run; ready_prev_q resets high so
   // an idle sequencer sitting at ready=1 after reset is not mistaken for one.
   assign complete = ready && !ready_prev_q;

   // Arithmetic registers: load > add > shift > hold.
   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no branch can leave it unassigned and infer a latch.
      m_d = m_q;
      q_d = q_q;
      a_d = a_q;
      c_d = c_q;
      if (resetout) begin
         m_d = multiplicand_in;
         q_d = multiplier_in;
         a_d = '0;
         c_d = 1'b0;
      end else if (add) begin
         {c_d, a_d} = {1'b0, a_q} + {1'b0, m_q};
      end else if (!ready) begin
         {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[N-1:1]};
      end
   end

   // Product capture and handshake; a fresh capture takes precedence over an ack.
   always_comb begin
      product_d = product_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (complete) begin
         product_d = {a_q, q_q};
         valid_d   = 1'b1;
         if (valid_q && !product_ack) begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && product_ack) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         m_q          <= '0;
         q_q          <= '0;
         a_q          <= '0;
         c_q          <= 1'b0;
         product_q    <= '0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
         ready_prev_q <= 1'b1;
      end else begin
         m_q          <= m_d;
         q_q          <= q_d;
         a_q          <= a_d;
         c_q          <= c_d;
         product_q    <= product_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
         ready_prev_q <= ready;
      end
   end

   assign Q0            = q_q[0];
   assign product       = product_q;
   assign product_valid = valid_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_shift_add_datapath.sv
// Directed bench for shift_add_datapath: the bench plays the sequencer and
// checks products, handshake, overrun and mid-run disturbances.
module tb_shift_add_datapath;

   localparam int unsigned N = 8;

   logic           clock = 1'b0;
   logic           n_reset = 1'b0;
   logic [N-1:0]   multiplicand_in = '0;
   logic [N-1:0]   multiplier_in = '0;
   logic           resetout = 1'b0;
   logic           add = 1'b0;
   logic           ready = 1'b1;
   logic           Q0;
   logic [2*N-1:0] product;
   logic           product_valid;
   logic           product_ack = 1'b0;
   logic           overrun;

   int n_checks = 0;
   int n_fail   = 0;

   // Bench-side model of the arithmetic registers.
   logic [N-1:0] m_m, q_m, a_m;
   logic         c_m;
   logic         carry_seen;

   shift_add_datapath #(.N(N)) dut (
      .clock           (clock),
      .n_reset         (n_reset),
      .multiplicand_in (multiplicand_in),
      .multiplier_in   (multiplier_in),
      .resetout        (resetout),
      .add             (add),
      .ready           (ready),
      .Q0              (Q0),
      .product         (product),
      .product_valid   (product_valid),
      .product_ack     (product_ack),
      .overrun         (overrun)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [N-1:0] mc, input logic [N-1:0] mp);
      multiplicand_in = mc;
      multiplier_in   = mp;
      resetout        = 1'b1;
      tick();
      resetout = 1'b0;
      m_m = mc;
      q_m = mp;
      a_m = '0;
      c_m = 1'b0;
      check("load_q0", Q0, mp[0]);
   endtask

   // Sequencer emulation: per bit, add when Q0 is set, then shift.
   task automatic step_bits(input int nbits, input string tag);
      ready = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         check({tag, "_q0"}, Q0, q_m[0]);
         if (q_m[0]) begin
            add = 1'b1;
            tick();
            add = 1'b0;
            {c_m, a_m} = {1'b0, a_m} + {1'b0, m_m};
            if (dut.c_q === 1'b1) carry_seen = 1'b1;
            check({tag, "_add_ca"}, {dut.c_q, dut.a_q}, {c_m, a_m});
         end
         tick();
         {c_m, a_m, q_m} = {1'b0, c_m, a_m, q_m[N-1:1]};
      end
   endtask

   task automatic complete(input logic ack_same, input logic [2*N-1:0] exp, input string tag);
      ready       = 1'b1;
      product_ack = ack_same;
      tick();
      product_ack = 1'b0;
      check({tag, "_product"}, product, exp);
      check({tag, "_valid"}, product_valid, 1'b1);
   endtask

   task automatic run(input logic [N-1:0] mc, input logic [N-1:0] mp,
                      input logic [2*N-1:0] exp, input string tag);
      do_load(mc, mp);
      step_bits(N, tag);
      complete(1'b0, exp, tag);
   endtask

   task automatic ack_product();
      product_ack = 1'b1;
      tick();
      product_ack = 1'b0;
   endtask

   initial begin
      carry_seen = 1'b0;
      m_m = '0; q_m = '0; a_m = '0; c_m = 1'b0;

      // Reset state, then release while the sequencer idles with ready=1.
      #2;
      check("rst_product", product, 0);
      check("rst_valid", product_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_q0", Q0, 0);
      tick();
      n_reset = 1'b1;
      repeat (3) tick();
      check("idle_no_capture", product_valid, 0);

      // 13 x 11: Q0 sequence 1,1,0,1 is checked inside step_bits.
      run(8'd13, 8'd11, 16'd143, "p13x11");
      check("p13x11_overrun", overrun, 0);

      // Asynchronous reset in the middle of a cycle clears everything at once.
      #3;
      n_reset = 1'b0;
      #1;
      check("async_product", product, 0);
      check("async_valid", product_valid, 0);
      check("async_q0", Q0, 0);
      check("async_overrun", overrun, 0);
      tick();
      n_reset = 1'b1;
      repeat (2) tick();
      check("async_no_capture", product_valid, 0);

      // Carry path.
      carry_seen = 1'b0;
      run(8'd255, 8'd255, 16'd65025, "p255x255");
      check("carry_seen", carry_seen, 1'b1);
      ack_product();
      check("ack_clears_valid", product_valid, 0);

      // Zero operands: multiplier 0 gives no adds and Q0 stays 0.
      run(8'd200, 8'd0, 16'd0, "p200x0");
      ack_product();
      run(8'd0, 8'd200, 16'd0, "p0x200");
      ack_product();
      check("idle_ack_valid", product_valid, 0);
      ack_product();
      check("stray_ack_ignored", product_valid, 0);

      // Overrun: an unacked result is overwritten.
      run(8'd2, 8'd3, 16'd6, "p2x3");
      check("p2x3_no_overrun", overrun, 0);
      run(8'd4, 8'd5, 16'd20, "p4x5");
      check("overrun_set", overrun, 1);
      ack_product();
      check("overrun_ack_valid", product_valid, 0);
      check("overrun_sticky", overrun, 1);

      // Clear overrun, then completion coinciding with an ack.
      n_reset = 1'b0;
      #1;
      check("overrun_cleared", overrun, 0);
      tick();
      n_reset = 1'b1;
      tick();
      run(8'd6, 8'd7, 16'd42, "p6x7");
      do_load(8'd3, 8'd3);
      step_bits(N, "p3x3");
      complete(1'b1, 16'd9, "p3x3_ack");
      check("simul_no_overrun", overrun, 0);
      ack_product();
      check("simul_then_ack", product_valid, 0);

      // Reset after 3 shifts: state cleared, no capture with ready held high.
      do_load(8'd13, 8'd11);
      step_bits(3, "part");
      #3;
      n_reset = 1'b0;
      ready   = 1'b1;
      #1;
      check("mid_rst_a", dut.a_q, 0);
      check("mid_rst_q0", Q0, 0);
      check("mid_rst_product", product, 0);
      tick();
      n_reset = 1'b1;
      repeat (3) tick();
      check("mid_rst_no_capture", product_valid, 0);

      // resetout mid-run restarts with 7 x 9; ready stays low so no capture.
      do_load(8'd5, 8'd6);
      step_bits(4, "p5x6");
      do_load(8'd7, 8'd9);
      check("reload_no_capture", product_valid, 0);
      step_bits(N, "p7x9");
      complete(1'b0, 16'd63, "p7x9");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
